// File: rtl/calc1_rr_scheduler_if.sv
// Bundle of the four calc1 requester/response ports and the shared ALU issue/complete signals.
// The scheduler takes the slave side; the environment (requesters plus ALU) takes the master side.
interface calc1_rr_scheduler_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CMD_W  = 4
);
    logic [0:CMD_W-1]  req1_cmd_in,  req2_cmd_in,  req3_cmd_in,  req4_cmd_in;
    logic [0:DATA_W-1] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
    logic [0:1]        out_resp1, out_resp2, out_resp3, out_resp4;
    logic [0:DATA_W-1] out_data1, out_data2, out_data3, out_data4;

    logic              alu_start;
    logic [0:CMD_W-1]  alu_cmd;
    logic [0:DATA_W-1] alu_op1, alu_op2;
    logic              alu_done;
    logic [0:1]        alu_resp;
    logic [0:DATA_W-1] alu_data;

    modport master (
        output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
        output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
        input  out_resp1, out_resp2, out_resp3, out_resp4,
        input  out_data1, out_data2, out_data3, out_data4,
        input  alu_start, alu_cmd, alu_op1, alu_op2,
        output alu_done, alu_resp, alu_data
    );

    modport slave (
        input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
        input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
        output out_resp1, out_resp2, out_resp3, out_resp4,
        output out_data1, out_data2, out_data3, out_data4,
        output alu_start, alu_cmd, alu_op1, alu_op2,
        input  alu_done, alu_resp, alu_data
    );
endinterface

// File: rtl/calc1_rr_scheduler.sv
// Four calc1 requester ports sharing one single-issue ALU through a round-robin arbiter.
// ALU issue and port responses are decoded from registered state only.
module calc1_rr_scheduler (
    input  logic                  c_clk,
    input  logic [1:7]            reset,
    calc1_rr_scheduler_if.slave   bus
);
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CMD_W   = 4;
    localparam int unsigned N_PORTS = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_OP2, ST_PEND, ST_RESP} state_t;

    logic                 w_rst;
    logic [0:CMD_W-1]     w_cmd       [N_PORTS];
    logic [0:DATA_W-1]    w_din       [N_PORTS];
    state_t               r_state     [N_PORTS];
    state_t               w_state_nxt [N_PORTS];
    logic [0:CMD_W-1]     r_cmd       [N_PORTS];
    logic [0:DATA_W-1]    r_op1       [N_PORTS];
    logic [0:DATA_W-1]    r_op2       [N_PORTS];
    logic [0:1]           r_rsp       [N_PORTS];
    logic [0:DATA_W-1]    r_rdata     [N_PORTS];
    logic [0:1]           w_resp      [N_PORTS];
    logic [0:DATA_W-1]    w_dout      [N_PORTS];
    logic [N_PORTS-1:0]   w_done_hit;
    logic                 r_busy;
    logic [1:0]           r_gnt;
    logic [1:0]           r_ptr;
    logic                 w_issue;
    logic [1:0]           w_gnt_idx;

    // Bits 2..7 of reset carry no meaning.
    assign w_rst = reset[1] | (1'b0 & (^reset[2:7]));

    assign w_cmd[0] = bus.req1_cmd_in;   assign w_din[0] = bus.req1_data_in;
    assign w_cmd[1] = bus.req2_cmd_in;   assign w_din[1] = bus.req2_data_in;
    assign w_cmd[2] = bus.req3_cmd_in;   assign w_din[2] = bus.req3_data_in;
    assign w_cmd[3] = bus.req4_cmd_in;   assign w_din[3] = bus.req4_data_in;

    assign bus.out_resp1 = w_resp[0];    assign bus.out_data1 = w_dout[0];
    assign bus.out_resp2 = w_resp[1];    assign bus.out_data2 = w_dout[1];
    assign bus.out_resp3 = w_resp[2];    assign bus.out_data3 = w_dout[2];
    assign bus.out_resp4 = w_resp[3];    assign bus.out_data4 = w_dout[3];

    function automatic logic f_cmd_valid(input logic [0:CMD_W-1] cmd);
        return (cmd == CMD_W'(1)) || (cmd == CMD_W'(2)) ||
               (cmd == CMD_W'(5)) || (cmd == CMD_W'(6));
    endfunction

    // First PEND port at or after the pointer, only while no operation is outstanding.
    always_comb begin
        w_issue   = 1'b0;
        w_gnt_idx = r_ptr;
        for (int k = 0; k < int'(N_PORTS); k++) begin
            if (!r_busy && !w_issue && r_state[2'(r_ptr + 2'(k))] == ST_PEND) begin
                w_issue   = 1'b1;
                w_gnt_idx = 2'(r_ptr + 2'(k));
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(N_PORTS); i++) begin
            w_done_hit[i] = r_busy && bus.alu_done && (r_gnt == 2'(i)) &&
                            (r_state[i] == ST_PEND);
        end
    end

    always_ff @(posedge c_clk) begin
        for (int i = 0; i < int'(N_PORTS); i++) begin
            if (w_rst) r_state[i] <= ST_IDLE;
            else       r_state[i] <= w_state_nxt[i];
        end
    end

    always_comb begin
        for (int i = 0; i < int'(N_PORTS); i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                ST_IDLE: if (w_cmd[i] != '0) w_state_nxt[i] = ST_OP2;
                ST_OP2:  w_state_nxt[i] = f_cmd_valid(r_cmd[i]) ? ST_PEND : ST_RESP;
                ST_PEND: if (w_done_hit[i]) w_state_nxt[i] = ST_RESP;
                ST_RESP: w_state_nxt[i] = ST_IDLE;
                default: w_state_nxt[i] = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.alu_start = w_issue;
        bus.alu_cmd   = '0;
        bus.alu_op1   = '0;
        bus.alu_op2   = '0;
        if (w_issue) begin
            bus.alu_cmd = r_cmd[w_gnt_idx];
            bus.alu_op1 = r_op1[w_gnt_idx];
            bus.alu_op2 = r_op2[w_gnt_idx];
        end
        for (int i = 0; i < int'(N_PORTS); i++) begin
            w_resp[i] = '0;
            w_dout[i] = '0;
            if (r_state[i] == ST_RESP) begin
                w_resp[i] = r_rsp[i];
                w_dout[i] = r_rdata[i];
            end
        end
    end

    // Request capture, response capture and arbiter bookkeeping.
    always_ff @(posedge c_clk) begin
        if (w_rst) begin
            r_busy <= 1'b0;
            r_gnt  <= '0;
            r_ptr  <= '0;
            for (int i = 0; i < int'(N_PORTS); i++) begin
                r_cmd[i]   <= '0;
                r_op1[i]   <= '0;
                r_op2[i]   <= '0;
                r_rsp[i]   <= '0;
                r_rdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_PORTS); i++) begin
                if (r_state[i] == ST_IDLE && w_cmd[i] != '0) begin
                    r_cmd[i] <= w_cmd[i];
                    r_op1[i] <= w_din[i];
                end
                if (r_state[i] == ST_OP2) begin
                    r_op2[i] <= w_din[i];
                    if (!f_cmd_valid(r_cmd[i])) begin
                        r_rsp[i]   <= 2'd2;
                        r_rdata[i] <= '0;
                    end
                end
                if (w_done_hit[i]) begin
                    r_rsp[i]   <= bus.alu_resp;
                    r_rdata[i] <= (bus.alu_resp == 2'd1) ? bus.alu_data : '0;
                end
            end
            if (w_issue) begin
                r_busy <= 1'b1;
                r_gnt  <= w_gnt_idx;
                r_ptr  <= 2'(w_gnt_idx + 2'd1);
            end else if (bus.alu_done) begin
                r_busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_calc1_rr_scheduler.sv
// Scoreboard bench for calc1_rr_scheduler with an L=2 ALU model; expected issues and
// responses are queued when requests are launched and checked as the DUT produces them.
module tb_calc1_rr_scheduler;
    localparam int ALU_L = 2;

    typedef struct { logic [0:3] cmd; logic [0:31] a; logic [0:31] b; int cyc; } iss_t;
    typedef struct { logic [0:1] r; logic [0:31] d; int cyc; } rsp_t;

    logic       c_clk = 1'b0;
    logic [1:7] reset = 7'b1000000;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    iss_t       iss_q[$];
    rsp_t       rsp_q[4][$];

    logic [0:3]  st_cmd [4];
    logic [0:31] st_op1 [4];
    logic [0:31] st_op2 [4];
    int          st_ord [4];

    bit          m_busy = 1'b0;
    int          m_done_cyc = 0;
    logic [0:1]  m_r;
    logic [0:31] m_d;
    bit          spurious = 1'b0;

    calc1_rr_scheduler_if bus();

    calc1_rr_scheduler dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 c_clk = ~c_clk;
    always @(posedge c_clk) cyc <= cyc + 1;

    function automatic void alu_fn(input logic [0:3] c, input logic [0:31] a, input logic [0:31] b,
                                   output logic [0:1] r, output logic [0:31] d);
        logic [32:0] s;
        case (c)
            4'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[32] ? 2'd2 : 2'd1; d = s[31:0]; end
            4'd2: begin s = {1'b0, a} - {1'b0, b}; r = s[32] ? 2'd2 : 2'd1; d = s[31:0]; end
            4'd5: begin r = 2'd1; d = a << b[27:31]; end
            4'd6: begin r = 2'd1; d = a >> b[27:31]; end
            default: begin r = 2'd2; d = '0; end
        endcase
    endfunction

    function automatic bit cmd_ok(input logic [0:3] c);
        return c inside {4'd1, 4'd2, 4'd5, 4'd6};
    endfunction

    function automatic logic [0:1] get_resp(input int p);
        case (p)
            0: return bus.out_resp1;
            1: return bus.out_resp2;
            2: return bus.out_resp3;
            default: return bus.out_resp4;
        endcase
    endfunction

    function automatic logic [0:31] get_data(input int p);
        case (p)
            0: return bus.out_data1;
            1: return bus.out_data2;
            2: return bus.out_data3;
            default: return bus.out_data4;
        endcase
    endfunction

    task automatic set_port(input int p, input logic [0:3] c, input logic [0:31] d);
        case (p)
            0: begin bus.req1_cmd_in = c; bus.req1_data_in = d; end
            1: begin bus.req2_cmd_in = c; bus.req2_data_in = d; end
            2: begin bus.req3_cmd_in = c; bus.req3_data_in = d; end
            default: begin bus.req4_cmd_in = c; bus.req4_data_in = d; end
        endcase
    endtask

    task automatic set_ord(input int o0, input int o1, input int o2, input int o3);
        st_ord[0] = o0; st_ord[1] = o1; st_ord[2] = o2; st_ord[3] = o3;
    endtask

    // Drives the ports in mask together; st_ord lists the expected grant order.
    task automatic launch(input logic [3:0] mask, input bit exp_resp);
        int t0;
        iss_t ie;
        rsp_t re;
        logic [0:1] r;
        logic [0:31] d;
        @(negedge c_clk);
        t0 = cyc;
        for (int j = 0; j < 4; j++) begin
            if (st_ord[j] >= 0) begin
                alu_fn(st_cmd[st_ord[j]], st_op1[st_ord[j]], st_op2[st_ord[j]], r, d);
                ie.cmd = st_cmd[st_ord[j]]; ie.a = st_op1[st_ord[j]]; ie.b = st_op2[st_ord[j]];
                ie.cyc = t0 + 2 + j * (ALU_L + 1);
                iss_q.push_back(ie);
                if (exp_resp) begin
                    re.r = r; re.d = (r == 2'd1) ? d : 32'h0; re.cyc = ie.cyc + ALU_L + 1;
                    rsp_q[st_ord[j]].push_back(re);
                end
            end
        end
        for (int p = 0; p < 4; p++) begin
            if (mask[p] && !cmd_ok(st_cmd[p])) begin
                re.r = 2'd2; re.d = 32'h0; re.cyc = t0 + 2;
                rsp_q[p].push_back(re);
            end
            if (mask[p]) set_port(p, st_cmd[p], st_op1[p]);
        end
        @(negedge c_clk);
        for (int p = 0; p < 4; p++) if (mask[p]) set_port(p, 4'd0, st_op2[p]);
        @(negedge c_clk);
        for (int p = 0; p < 4; p++) if (mask[p]) set_port(p, 4'd0, 32'h0);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge c_clk);
            done = (iss_q.size() == 0) && !m_busy && (rsp_q[0].size() == 0) &&
                   (rsp_q[1].size() == 0) && (rsp_q[2].size() == 0) && (rsp_q[3].size() == 0);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: queues still hold issues=%0d, wanted empty", iss_q.size());
        end
        repeat (2) @(negedge c_clk);
    endtask

    // ALU model: L-cycle latency, drops its operation on reset.
    always @(posedge c_clk) begin : alu_model
        iss_t ie;
        #1;
        bus.alu_done = 1'b0;
        bus.alu_resp = 2'd0;
        bus.alu_data = 32'h0;
        if (reset[1]) begin
            m_busy = 1'b0;
        end else begin
            if (m_busy && cyc == m_done_cyc) begin
                bus.alu_done = 1'b1; bus.alu_resp = m_r; bus.alu_data = m_d;
                m_busy = 1'b0;
            end
            if (spurious) begin
                bus.alu_done = 1'b1; bus.alu_resp = 2'd1; bus.alu_data = 32'hDEADBEEF;
                spurious = 1'b0;
            end
            if (bus.alu_start) begin
                checks++;
                if (iss_q.size() == 0 || m_busy) begin
                    errors++;
                    $display("FAIL unexpected_issue: cyc=%0d cmd=%0d op1=%h op2=%h busy=%0b, wanted no issue",
                             cyc, bus.alu_cmd, bus.alu_op1, bus.alu_op2, m_busy);
                end else begin
                    ie = iss_q.pop_front();
                    if ({bus.alu_cmd, bus.alu_op1, bus.alu_op2} !== {ie.cmd, ie.a, ie.b} || cyc != ie.cyc) begin
                        errors++;
                        $display("FAIL issue: got cmd=%0d op1=%h op2=%h cyc=%0d, wanted cmd=%0d op1=%h op2=%h cyc=%0d",
                                 bus.alu_cmd, bus.alu_op1, bus.alu_op2, cyc, ie.cmd, ie.a, ie.b, ie.cyc);
                    end
                end
                alu_fn(bus.alu_cmd, bus.alu_op1, bus.alu_op2, m_r, m_d);
                m_done_cyc = cyc + ALU_L;
                m_busy = 1'b1;
            end else begin
                checks++;
                if ({bus.alu_cmd, bus.alu_op1, bus.alu_op2} !== '0) begin
                    errors++;
                    $display("FAIL idle_issue_bus: got cmd=%0d op1=%h op2=%h, wanted 0",
                             bus.alu_cmd, bus.alu_op1, bus.alu_op2);
                end
            end
        end
    end

    // Response monitor: every nonzero response must match the head of its port queue.
    always @(negedge c_clk) begin : resp_mon
        rsp_t re;
        logic [0:1] r;
        logic [0:31] d;
        if (!reset[1]) begin
            for (int p = 0; p < 4; p++) begin
                r = get_resp(p);
                d = get_data(p);
                checks++;
                if (r != 2'd0) begin
                    if (rsp_q[p].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_resp: port%0d cyc=%0d got resp=%0d data=%h, wanted none",
                                 p + 1, cyc, r, d);
                    end else begin
                        re = rsp_q[p].pop_front();
                        if (r !== re.r || d !== re.d || cyc != re.cyc) begin
                            errors++;
                            $display("FAIL resp_port%0d: got resp=%0d data=%h cyc=%0d, wanted resp=%0d data=%h cyc=%0d",
                                     p + 1, r, d, cyc, re.r, re.d, re.cyc);
                        end
                    end
                end else if (d !== 32'h0) begin
                    errors++;
                    $display("FAIL data_without_resp: port%0d got data=%h, wanted 0", p + 1, d);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (get_resp(p) !== 2'd0 || get_data(p) !== 32'h0) begin
                errors++;
                $display("FAIL %s_port%0d: got resp=%0d data=%h, wanted 0/0", tag, p + 1, get_resp(p), get_data(p));
            end
        end
        checks++;
        if ({bus.alu_start, bus.alu_cmd, bus.alu_op1, bus.alu_op2} !== '0) begin
            errors++;
            $display("FAIL %s_alu: got start=%0b cmd=%0d op1=%h op2=%h, wanted 0", tag,
                     bus.alu_start, bus.alu_cmd, bus.alu_op1, bus.alu_op2);
        end
    endtask

    task automatic test_reset();
        for (int p = 0; p < 4; p++) set_port(p, 4'd0, 32'h0);
        repeat (2) @(negedge c_clk);
        check_all_zero("reset");
        reset = 7'b0111111;
        repeat (2) @(negedge c_clk);
        check_all_zero("after_reset");
    endtask

    task automatic test_all_ports();
        for (int p = 0; p < 4; p++) begin
            st_cmd[p] = 4'd1;
            st_op1[p] = 32'h1000 * (p + 1);
            st_op2[p] = 32'h11 * (p + 1);
        end
        set_ord(0, 1, 2, 3);
        launch(4'b1111, 1'b1);
        wait_drain();
    endtask

    task automatic test_single();
        st_cmd[0] = 4'd1; st_op1[0] = 32'h00000001; st_op2[0] = 32'h1FFFFFFF;
        set_ord(0, -1, -1, -1);
        launch(4'b0001, 1'b1);
        wait_drain();
    endtask

    task automatic test_pointer();
        st_cmd[1] = 4'd5; st_op1[1] = 32'h00000003; st_op2[1] = 32'h00000004;
        set_ord(1, -1, -1, -1);
        launch(4'b0010, 1'b1);
        wait_drain();
        st_cmd[0] = 4'd1; st_op1[0] = 32'hFFFFFFFF; st_op2[0] = 32'h00000001;
        st_cmd[3] = 4'd2; st_op1[3] = 32'h00000100; st_op2[3] = 32'h00000001;
        set_ord(3, 0, -1, -1);
        launch(4'b1001, 1'b1);
        wait_drain();
    endtask

    task automatic test_invalid();
        st_cmd[0] = 4'd6; st_op1[0] = 32'h80000000; st_op2[0] = 32'h00000004;
        st_cmd[1] = 4'd3; st_op1[1] = 32'h12345678; st_op2[1] = 32'h00000001;
        set_ord(0, -1, -1, -1);
        launch(4'b0011, 1'b1);
        wait_drain();
        st_cmd[1] = 4'd4;
        set_ord(-1, -1, -1, -1);
        launch(4'b0010, 1'b1);
        wait_drain();
    endtask

    task automatic test_alu_error();
        st_cmd[0] = 4'd2; st_op1[0] = 32'h00000001; st_op2[0] = 32'h0000000F;
        set_ord(0, -1, -1, -1);
        launch(4'b0001, 1'b1);
        wait_drain();
        spurious = 1'b1;
        repeat (4) begin
            @(negedge c_clk);
            check_all_zero("spurious_done");
        end
    endtask

    task automatic test_reset_inflight();
        st_cmd[2] = 4'd1; st_op1[2] = 32'h00000007; st_op2[2] = 32'h00000008;
        set_ord(2, -1, -1, -1);
        launch(4'b0100, 1'b0);
        @(negedge c_clk);
        reset = 7'b1000000;
        @(negedge c_clk);
        check_all_zero("reset_inflight");
        reset = 7'b0111111;
        repeat (6) @(negedge c_clk);
        st_cmd[0] = 4'd1; st_op1[0] = 32'h00000005; st_op2[0] = 32'h00000006;
        st_cmd[3] = 4'd6; st_op1[3] = 32'h0000F000; st_op2[3] = 32'h00000004;
        set_ord(0, 3, -1, -1);
        launch(4'b1001, 1'b1);
        wait_drain();
    endtask

    initial begin
        bus.alu_done = 1'b0;
        bus.alu_resp = 2'd0;
        bus.alu_data = 32'h0;
        set_ord(-1, -1, -1, -1);
        test_reset();
        test_all_ports();
        test_single();
        test_pointer();
        test_invalid();
        test_alu_error();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at cyc=%0d, wanted finish", cyc);
        $fatal(1, "watchdog");
    end
endmodule
